// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives the falling-edge instruction ROM and hands
// captured words to the decoder over a valid/ready handshake.
module instr_fetch_unit #(
  parameter int START_ADDR = 0,
  parameter int LAST_ADDR  = 31,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             redirect_valid,
  input  logic [4:0]       redirect_pc,
  output logic [4:0]       rom_addr,
  input  logic [31:0]      rom_data,
  output logic [31:0]      instr,
  output logic [4:0]       instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic             done,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [4:0]       START_PC = 5'(START_ADDR);
  localparam logic [4:0]       LAST_PC  = 5'(LAST_ADDR);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [4:0]       pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [4:0]       instr_pc_q, instr_pc_d;
  logic             instr_valid_q, instr_valid_d;
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;
  logic             accept;

  assign accept = !instr_valid_q || instr_ready;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fetch_count_d = fetch_count_q;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_valid) begin
          pc_d          = redirect_pc;
          instr_valid_d = 1'b0;
        end else if (accept) begin
          // rom_data now holds the word latched from pc_q on the last falling edge.
          instr_d       = rom_data;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          if (fetch_count_q != CNT_MAX) fetch_count_d = fetch_count_q + 1'b1;
          if (pc_q >= LAST_PC) state_d = ST_DONE;
          else                 pc_d    = pc_q + 5'd1;
        end
      end
      ST_DONE: begin
        if (redirect_valid) begin
          pc_d          = redirect_pc;
          instr_valid_d = 1'b0;
          state_d       = ST_RUN;
        end else if (start) begin
          pc_d          = START_PC;
          fetch_count_d = '0;
          instr_valid_d = 1'b0;
          state_d       = ST_RUN;
        end else if (instr_valid_q && instr_ready) begin
          instr_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= START_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign rom_addr    = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign done        = (state_q == ST_DONE);
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: falling-edge ROM model, scoreboard
// of expected (pc, word) pairs popped on each decoder handshake.
module tb_instr_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        redirect_valid;
  logic [4:0]  redirect_pc;
  logic [4:0]  rom_addr;
  logic [31:0] rom_data = '0;
  logic [31:0] instr;
  logic [4:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        done;
  logic [15:0] fetch_count;

  logic [31:0] rom [32];
  logic [36:0] sb [$];
  int total = 0;
  int bad   = 0;

  instr_fetch_unit #(.START_ADDR(0), .LAST_ADDR(2), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .start(start),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .done(done), .fetch_count(fetch_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) rom_data <= rom[rom_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input int a);
    sb.push_back({5'(a), rom[a]});
  endtask

  // A word is consumed whenever valid and ready meet at the coming edge.
  always @(negedge clock) begin
    if (!reset && instr_valid && instr_ready) begin
      check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) check("sb_word", 64'({instr_pc, instr}), 64'(sb.pop_front()));
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'hdead_0000 | 32'(i);
    rom[0] = 32'h0022_0020;
    rom[1] = 32'h0022_0022;
    rom[2] = 32'h0022_0026;

    reset = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_instr_pc", 64'(instr_pc), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_count", 64'(fetch_count), 64'd0);
    check("rst_rom_addr", 64'(rom_addr), 64'd0);

    // Basic run
    for (int a = 0; a < 3; a++) push_exp(a);
    start = 1'b1; step(); start = 1'b0;
    check("run_first_not_yet", 64'(instr_valid), 64'd0);
    for (int a = 0; a < 3; a++) begin
      step();
      check("run_instr", 64'(instr), 64'(rom[a]));
      check("run_pc", 64'(instr_pc), 64'(a));
      check("run_valid", 64'(instr_valid), 64'd1);
    end
    check("run_done_early", 64'(done), 64'd1);
    step();
    check("run_end_valid", 64'(instr_valid), 64'd0);
    check("run_end_done", 64'(done), 64'd1);
    check("run_end_count", 64'(fetch_count), 64'd3);

    // Start and redirect together in DONE: redirect wins, count kept
    push_exp(1); push_exp(2);
    start = 1'b1; redirect_valid = 1'b1; redirect_pc = 5'd1;
    step();
    start = 1'b0; redirect_valid = 1'b0;
    check("sim_count_kept", 64'(fetch_count), 64'd3);
    check("sim_done", 64'(done), 64'd0);
    check("sim_rom_addr", 64'(rom_addr), 64'd1);
    step();
    check("sim_instr", 64'(instr), 64'h0022_0022);
    check("sim_count4", 64'(fetch_count), 64'd4);
    step();
    check("sim_pc2", 64'(instr_pc), 64'd2);
    step();
    check("sim_end_done", 64'(done), 64'd1);
    check("sim_end_count", 64'(fetch_count), 64'd5);

    // Restart, then backpressure while pc1 is presented
    start = 1'b1; step(); start = 1'b0;
    check("rs_count_clr", 64'(fetch_count), 64'd0);
    check("rs_done", 64'(done), 64'd0);
    check("rs_valid", 64'(instr_valid), 64'd0);
    push_exp(0); push_exp(1); push_exp(2);
    step();
    check("rs_instr0", 64'(instr), 64'(rom[0]));
    step();
    instr_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("bp_instr", 64'(instr), 64'h0022_0022);
      check("bp_pc", 64'(instr_pc), 64'd1);
      check("bp_rom_addr", 64'(rom_addr), 64'd2);
      check("bp_count", 64'(fetch_count), 64'd2);
    end
    instr_ready = 1'b1;
    step();
    check("bp_release_pc", 64'(instr_pc), 64'd2);
    check("bp_release_count", 64'(fetch_count), 64'd3);
    step();
    check("bp_end_done", 64'(done), 64'd1);
    check("bp_end_valid", 64'(instr_valid), 64'd0);

    // Redirect to 0 while pc1 is presented and accepted
    start = 1'b1; step(); start = 1'b0;
    push_exp(0); push_exp(1);
    step();
    step();
    check("rd_pre_pc", 64'(instr_pc), 64'd1);
    redirect_valid = 1'b1; redirect_pc = 5'd0;
    step();
    redirect_valid = 1'b0;
    check("rd_flush", 64'(instr_valid), 64'd0);
    check("rd_count_held", 64'(fetch_count), 64'd2);
    push_exp(0); push_exp(1); push_exp(2);
    step();
    check("rd_instr", 64'(instr), 64'h0022_0020);
    check("rd_pc", 64'(instr_pc), 64'd0);
    repeat (3) step();
    check("rd_end_done", 64'(done), 64'd1);
    check("rd_end_count", 64'(fetch_count), 64'd5);

    // Reset mid-run with pc_q=1 and decoder stalled
    start = 1'b1; step(); start = 1'b0;
    instr_ready = 1'b0;
    step();
    check("mr_pre_rom_addr", 64'(rom_addr), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mr_instr", 64'(instr), 64'd0);
    check("mr_pc", 64'(instr_pc), 64'd0);
    check("mr_valid", 64'(instr_valid), 64'd0);
    check("mr_done", 64'(done), 64'd0);
    check("mr_count", 64'(fetch_count), 64'd0);
    check("mr_rom_addr", 64'(rom_addr), 64'd0);
    instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 5'd2;
    step();
    redirect_valid = 1'b0;
    repeat (2) step();
    check("idle_rom_addr", 64'(rom_addr), 64'd0);
    check("idle_valid", 64'(instr_valid), 64'd0);
    check("idle_count", 64'(fetch_count), 64'd0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
